// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
// State encoding, port-select codes and parameter defaults.
package mem_arb_pkg;

  localparam int unsigned AW_DEF           = 32;
  localparam int unsigned DW_DEF           = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_I    = 2'd1,
    SEL_D    = 2'd2
  } port_sel_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between core (I/D ports), arbiter and memory.
// slave = arbiter view, master = core + memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_abort;
  logic [DW-1:0] i_rdata;
  logic          i_valid;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;

  logic          stall_f;
  logic          stall_m;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  i_req, i_addr, i_abort,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output i_rdata, i_valid,
    output d_rdata, d_valid,
    output stall_f, stall_m,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, i_abort,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  i_rdata, i_valid,
    input  d_rdata, d_valid,
    input  stall_f, stall_m,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating 4-bit count of D grants made while I waits.
// Ports: clk, rst_n, inc_i, clr_i (wins), at_limit_o.
module arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && cnt_q != 4'hF) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == 4'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D).
// Ports: clk, reset (active-low async), bus (slave modport).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_e    state_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          i_valid_q;
  logic          d_valid_q;
  logic          abort_q;

  logic          at_limit;
  logic          idle;
  port_sel_e     sel;

  assign idle = (state_q == IDLE);

  // D normally wins; I wins once D has starved it long enough.
  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      (bus.i_req & bus.d_req & at_limit):
        sel = SEL_I;
      (bus.d_req & ~(bus.i_req & at_limit)):
        sel = SEL_D;
      (bus.i_req & ~bus.d_req):
        sel = SEL_I;
      default:
        sel = SEL_NONE;
    endcase
  end

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst_n     (reset),
    .inc_i     (idle & (sel == SEL_D) & bus.i_req),
    .clr_i     (idle & (sel == SEL_I)),
    .at_limit_o(at_limit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          unique case (sel)
            SEL_D: begin
              state_q     <= BUSY_D;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
            end
            SEL_I: begin
              state_q    <= BUSY_I;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= bus.i_addr;
            end
            default: ;
          endcase
        end
        BUSY_I: begin
          if (bus.mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            i_rdata_q <= bus.mem_rdata;
            // A redirect seen at any point of the access kills the result.
            i_valid_q <= ~(abort_q | bus.i_abort);
            abort_q   <= 1'b0;
          end else if (bus.i_abort) begin
            abort_q <= 1'b1;
          end
        end
        BUSY_D: begin
          if (bus.mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            d_rdata_q <= bus.mem_rdata;
            d_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.stall_f   = bus.i_req & ~i_valid_q;
  assign bus.stall_m   = bus.d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus
// randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errs   = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.i_abort   = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.i_valid, bus.d_valid} !== 4'b0)
      $display("FAIL reset_ctl: got %b want 0000",
        {bus.mem_req, bus.mem_we, bus.i_valid, bus.d_valid});
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'h0)
      $display("FAIL reset_mem_bus: got %h want 0",
        {bus.mem_addr, bus.mem_wdata});
    checks++;
    if ({bus.i_rdata, bus.d_rdata} !== 64'h0)
      $display("FAIL reset_rdata: got %h want 0",
        {bus.i_rdata, bus.d_rdata});
    errs += (({bus.mem_req, bus.mem_we, bus.i_valid, bus.d_valid} !== 4'b0) ? 1 : 0)
          + (({bus.mem_addr, bus.mem_wdata} !== 64'h0) ? 1 : 0)
          + (({bus.i_rdata, bus.d_rdata} !== 64'h0) ? 1 : 0);
  endtask

  task automatic test_single_load();
    for (int c = 0; c < 6; c++) begin
      bus.d_req     = (c < 4);
      bus.d_we      = 1'b0;
      bus.d_addr    = 32'h40;
      bus.mem_ready = (c == 3);
      bus.mem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge clk);
      checks++;
      if (bus.stall_m !== (c < 4)) begin
        errs++;
        $display("FAIL load_stall_m c%0d: got %b want %b", c, bus.stall_m, (c < 4));
      end
      checks++;
      if (bus.mem_req !== (c >= 1 && c <= 3)) begin
        errs++;
        $display("FAIL load_mem_req c%0d: got %b", c, bus.mem_req);
      end
      checks++;
      if (bus.d_valid !== (c == 4)) begin
        errs++;
        $display("FAIL load_d_valid c%0d: got %b", c, bus.d_valid);
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if ({bus.mem_we, bus.mem_addr} !== {1'b0, 32'h40}) begin
          errs++;
          $display("FAIL load_mem_addr c%0d: got %b/%h want 0/40", c, bus.mem_we, bus.mem_addr);
        end
      end
      if (c == 4) begin
        checks++;
        if (bus.d_rdata !== 32'hDEAD_BEEF) begin
          errs++;
          $display("FAIL load_d_rdata: got %h want deadbeef", bus.d_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < 6; c++) begin
      bus.i_req     = (c < 4);
      bus.i_addr    = 32'h200;
      bus.d_req     = (c < 2);
      bus.d_we      = 1'b0;
      bus.d_addr    = 32'h300;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hD000_0000 + 32'(c);
      @(negedge clk);
      checks++;
      if (bus.mem_req !== (c == 1 || c == 3)) begin
        errs++;
        $display("FAIL both_mem_req c%0d: got %b", c, bus.mem_req);
      end
      if (c == 1) begin
        checks++;
        if (bus.mem_addr !== 32'h300) begin
          errs++;
          $display("FAIL both_first_d: got %h want 300", bus.mem_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if ({bus.mem_we, bus.mem_addr} !== {1'b0, 32'h200}) begin
          errs++;
          $display("FAIL both_then_i: got %b/%h want 0/200", bus.mem_we, bus.mem_addr);
        end
      end
      checks++;
      if ({bus.d_valid, bus.i_valid} !== {(c == 2), (c == 4)}) begin
        errs++;
        $display("FAIL both_valids c%0d: got %b", c, {bus.d_valid, bus.i_valid});
      end
      checks++;
      if (bus.stall_f !== (c < 4)) begin
        errs++;
        $display("FAIL both_stall_f c%0d: got %b", c, bus.stall_f);
      end
      if (c == 2) begin
        checks++;
        if (bus.d_rdata !== 32'hD000_0001) begin
          errs++;
          $display("FAIL both_d_rdata: got %h want d0000001", bus.d_rdata);
        end
      end
      if (c == 4) begin
        checks++;
        if (bus.i_rdata !== 32'hD000_0003) begin
          errs++;
          $display("FAIL both_i_rdata: got %h want d0000003", bus.i_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    int got[$];
    int exp_q[$];
    int w;
    for (int c = 0; c < 24; c++) begin
      bus.i_req     = 1'b1;
      bus.i_addr    = 32'h500;
      bus.d_req     = 1'b1;
      bus.d_we      = 1'b0;
      if (c % 2 == 0)
        bus.d_addr = 32'h1000 + 32'(4 * c);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'(c);
      @(negedge clk);
      if (bus.mem_req === 1'b1)
        got.push_back((bus.mem_addr >= 32'h1000) ? 2 : 1);
      tick();
    end
    w = 0;
    for (int k = 0; k < 12; k++) begin
      if (w == LIM) begin
        exp_q.push_back(1);
        w = 0;
      end else begin
        exp_q.push_back(2);
        w++;
      end
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errs++;
      $display("FAIL starve_grant_count: got %0d want %0d", got.size(), exp_q.size());
    end
    for (int k = 0; k < 12; k++) begin
      if (k < got.size()) begin
        checks++;
        if (got[k] != exp_q[k]) begin
          errs++;
          $display("FAIL starve_grant%0d: got port %0d want %0d (1=I 2=D)", k, got[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_abort();
    for (int c = 0; c < 10; c++) begin
      bus.i_req     = (c == 0) || (c == 7) || (c == 8);
      bus.i_addr    = (c < 7) ? 32'h100 : 32'h180;
      bus.i_abort   = (c == 1);
      bus.mem_ready = (c == 4) || (c == 8);
      bus.mem_rdata = 32'hA0 + 32'(c);
      @(negedge clk);
      checks++;
      if (bus.mem_req !== ((c >= 1 && c <= 4) || c == 8)) begin
        errs++;
        $display("FAIL abort_mem_req c%0d: got %b", c, bus.mem_req);
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (bus.mem_addr !== 32'h100) begin
          errs++;
          $display("FAIL abort_addr_hold c%0d: got %h want 100", c, bus.mem_addr);
        end
      end
      checks++;
      if (bus.i_valid !== (c == 9)) begin
        errs++;
        $display("FAIL abort_i_valid c%0d: got %b", c, bus.i_valid);
      end
      if (c == 9) begin
        checks++;
        if (bus.i_rdata !== 32'hA8) begin
          errs++;
          $display("FAIL abort_refetch_rdata: got %h want a8", bus.i_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_store();
    for (int c = 0; c < 6; c++) begin
      bus.d_req     = (c < 4);
      bus.d_we      = 1'b1;
      bus.d_addr    = (c < 2) ? 32'h80 : 32'hBAD0;
      bus.d_wdata   = (c < 2) ? 32'h1234_5678 : 32'hCAFE_F00D;
      bus.mem_ready = (c == 3);
      bus.mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if (bus.mem_req !== (c >= 1 && c <= 3)) begin
        errs++;
        $display("FAIL store_mem_req c%0d: got %b", c, bus.mem_req);
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h80, 32'h1234_5678}) begin
          errs++;
          $display("FAIL store_bus c%0d: got %b/%h/%h want 1/80/12345678",
            c, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
      end
      checks++;
      if ({bus.d_valid, bus.i_valid, bus.stall_f} !== {(c == 4), 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL store_valid c%0d: got %b", c, {bus.d_valid, bus.i_valid, bus.stall_f});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h44;
    tick();
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_busy: got %b want 1", bus.mem_req);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_async_drop: got %b want 0", bus.mem_req);
    end
    bus.d_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.i_valid, bus.d_valid} !== 3'b000) begin
        errs++;
        $display("FAIL rstmid_after c%0d: got %b want 000", c,
          {bus.mem_req, bus.i_valid, bus.d_valid});
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit          live, fetch, dropped, take_i;
    bit          ev_i, ev_d;
    logic [31:0] t_addr, t_wdata, ex_ir, ex_dr;
    bit          t_we;
    int          wins;
    live = 0; fetch = 0; dropped = 0; ev_i = 0; ev_d = 0;
    t_addr = '0; t_wdata = '0; t_we = 0; ex_ir = '0; ex_dr = '0;
    wins = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.i_abort = 1'b0;
      if (!bus.i_req) begin
        if ($urandom_range(2) == 0) begin
          bus.i_req  = 1'b1;
          bus.i_addr = $urandom;
        end
      end else if (ev_i) begin
        if ($urandom_range(1) == 1) bus.i_req = 1'b0;
        else bus.i_addr = $urandom;
      end else if ($urandom_range(15) == 0) begin
        bus.i_abort = 1'b1;
        bus.i_addr  = $urandom;
      end
      if (!bus.d_req || ev_d) begin
        if (bus.d_req && $urandom_range(1) == 1) begin
          bus.d_req = 1'b0;
        end else if (bus.d_req || $urandom_range(2) == 0) begin
          bus.d_req   = 1'b1;
          bus.d_we    = 1'($urandom_range(1));
          bus.d_addr  = $urandom;
          bus.d_wdata = $urandom;
        end
      end
      bus.mem_ready = 1'($urandom_range(1));
      bus.mem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if (bus.mem_req !== live) begin
        errs++;
        $display("FAIL rand_mem_req n%0d: got %b want %b", n, bus.mem_req, live);
      end
      if (live) begin
        checks++;
        if ({bus.mem_we, bus.mem_addr} !== {t_we, t_addr}) begin
          errs++;
          $display("FAIL rand_mem_addr n%0d: got %b/%h want %b/%h",
            n, bus.mem_we, bus.mem_addr, t_we, t_addr);
        end
        if (t_we) begin
          checks++;
          if (bus.mem_wdata !== t_wdata) begin
            errs++;
            $display("FAIL rand_mem_wdata n%0d: got %h want %h", n, bus.mem_wdata, t_wdata);
          end
        end
      end
      checks++;
      if ({bus.i_valid, bus.d_valid} !== {ev_i, ev_d}) begin
        errs++;
        $display("FAIL rand_valids n%0d: got %b want %b", n,
          {bus.i_valid, bus.d_valid}, {ev_i, ev_d});
      end
      if (ev_i) begin
        checks++;
        if (bus.i_rdata !== ex_ir) begin
          errs++;
          $display("FAIL rand_i_rdata n%0d: got %h want %h", n, bus.i_rdata, ex_ir);
        end
      end
      if (ev_d) begin
        checks++;
        if (bus.d_rdata !== ex_dr) begin
          errs++;
          $display("FAIL rand_d_rdata n%0d: got %h want %h", n, bus.d_rdata, ex_dr);
        end
      end
      checks++;
      if ({bus.stall_f, bus.stall_m} !== {bus.i_req & ~ev_i, bus.d_req & ~ev_d}) begin
        errs++;
        $display("FAIL rand_stalls n%0d: got %b want %b", n,
          {bus.stall_f, bus.stall_m}, {bus.i_req & ~ev_i, bus.d_req & ~ev_d});
      end
      ev_i = 0;
      ev_d = 0;
      if (live) begin
        if (fetch && bus.i_abort) dropped = 1;
        if (bus.mem_ready) begin
          live = 0;
          if (fetch) begin
            ex_ir = bus.mem_rdata;
            ev_i  = !dropped;
          end else begin
            ex_dr = bus.mem_rdata;
            ev_d  = 1;
          end
        end
      end else if (bus.i_req || bus.d_req) begin
        take_i  = bus.i_req && (!bus.d_req || wins >= LIM);
        live    = 1;
        fetch   = take_i;
        dropped = 0;
        if (take_i) begin
          t_addr = bus.i_addr;
          t_we   = 0;
          wins   = 0;
        end else begin
          t_addr  = bus.d_addr;
          t_we    = bus.d_we;
          t_wdata = bus.d_wdata;
          if (bus.i_req && wins < 15) wins++;
        end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    do_reset();
    test_single_load();
    do_reset();
    test_simultaneous();
    do_reset();
    test_starvation();
    do_reset();
    test_abort();
    do_reset();
    test_store();
    do_reset();
    test_reset_mid();
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
